// File: rtl/div_share_ctrl.sv
// Shares one 32-bit unsigned iterative divider among NUM_REQ requesters with round-robin arbitration.
// Latency: gnt at T, result valid at T+DIV_LATENCY+1 (divide-by-zero bypass: T+1).
// Backpressure: response held stable in RESP until rsp_ready; no new grant until the response is taken.
//
// Optional feature macro: DIV_SHARE_FASTPATH_EN
//    When defined, divisor==1 and divisor>dividend are also resolved without the divider.
//
// Ports:
//    clk, reset          - rising-edge clock, asynchronous active-low reset
//    req                 - per-requester request level (hold with operands until gnt)
//    req_dividend/divisor- flattened operands, slice i = [32i+31:32i]
//    gnt                 - one-hot accept pulse, only issued in IDLE
//    busy                - high whenever an operation is in flight or awaiting handshake
//    rsp_*               - valid/ready response tagged with requester id, plus divide-by-zero flag
//    div_*               - connection to the shared divider datapath (enable, operands, results)
module div_share_ctrl #(
   parameter int NUM_REQ     = 4,
   parameter int DIV_LATENCY = 34,
   parameter int ID_W        = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*32-1:0] req_dividend,
   input  logic [NUM_REQ*32-1:0] req_divisor,
   output logic [NUM_REQ-1:0]    gnt,
   output logic                  busy,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_quotient,
   output logic [31:0]           rsp_remainder,
   output logic                  rsp_dbz,
   output logic                  div_enable,
   output logic [31:0]           div_dividend,
   output logic [31:0]           div_divisor,
   input  logic [31:0]           div_quotient,
   input  logic [31:0]           div_remainder
);

   // Counter only needs to hold DIV_LATENCY-1.
   localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   win;
   logic              any_req;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       sel_dividend;
   logic [31:0]       sel_divisor;

   // Round-robin pick: first requester found searching upward from ptr+1, wrapping.
   always_comb begin
      int  idx;
      logic found;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = ID_W'(idx);
         end
      end
   end

   assign any_req      = |req;
   assign sel_dividend = req_dividend[win*32 +: 32];
   assign sel_divisor  = req_divisor[win*32 +: 32];

   // Grant is a same-cycle pulse so the requester sees its operands sampled this cycle.
   // Gated by reset so nothing is granted while the block is held in reset.
   always_comb begin
      gnt = '0;
      if (reset && state == IDLE && any_req)
         gnt[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         ptr           <= ID_W'(NUM_REQ - 1);
         cnt           <= '0;
         busy          <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
         rsp_dbz       <= 1'b0;
         div_enable    <= 1'b0;
         div_dividend  <= '0;
         div_divisor   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  ptr    <= win;
                  rsp_id <= win;
                  busy   <= 1'b1;
                  if (sel_divisor == 32'd0) begin
                     rsp_quotient  <= 32'hFFFF_FFFF;
                     rsp_remainder <= sel_dividend;
                     rsp_dbz       <= 1'b1;
                     rsp_valid     <= 1'b1;
                     state         <= RESP;
                  end
`ifdef DIV_SHARE_FASTPATH_EN
                  else if (sel_divisor == 32'd1) begin
                     rsp_quotient  <= sel_dividend;
                     rsp_remainder <= 32'd0;
                     rsp_dbz       <= 1'b0;
                     rsp_valid     <= 1'b1;
                     state         <= RESP;
                  end else if (sel_divisor > sel_dividend) begin
                     rsp_quotient  <= 32'd0;
                     rsp_remainder <= sel_dividend;
                     rsp_dbz       <= 1'b0;
                     rsp_valid     <= 1'b1;
                     state         <= RESP;
                  end
`endif
                  else begin
                     // Operand registers double as the divider inputs, held for all of RUN.
                     div_dividend <= sel_dividend;
                     div_divisor  <= sel_divisor;
                     div_enable   <= 1'b1;
                     cnt          <= CNT_W'(DIV_LATENCY - 1);
                     state        <= RUN;
                  end
               end
            end
            RUN: begin
               if (cnt == '0) begin
                  // Last enabled cycle: the divider output is valid now.
                  rsp_quotient  <= div_quotient;
                  rsp_remainder <= div_remainder;
                  rsp_dbz       <= 1'b0;
                  rsp_valid     <= 1'b1;
                  div_enable    <= 1'b0;
                  div_dividend  <= '0;
                  div_divisor   <= '0;
                  state         <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_share_ctrl.sv
`timescale 1ns/1ps
module tb_div_share_ctrl;

   localparam int NUM_REQ = 4;
   localparam int LAT     = 34;
`ifdef DIV_SHARE_FASTPATH_EN
   localparam int FP_LAT = 1;
   localparam int FP_EN  = 0;
`else
   localparam int FP_LAT = LAT + 1;
   localparam int FP_EN  = LAT;
`endif

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*32-1:0] req_dividend;
   logic [NUM_REQ*32-1:0] req_divisor;
   logic [NUM_REQ-1:0]    gnt;
   logic                  busy;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [1:0]            rsp_id;
   logic [31:0]           rsp_quotient;
   logic [31:0]           rsp_remainder;
   logic                  rsp_dbz;
   logic                  div_enable;
   logic [31:0]           div_dividend;
   logic [31:0]           div_divisor;
   logic [31:0]           div_quotient;
   logic [31:0]           div_remainder;

   div_share_ctrl #(.NUM_REQ(NUM_REQ), .DIV_LATENCY(LAT), .ID_W(2)) dut (
      .clk(clk), .reset(reset), .req(req), .req_dividend(req_dividend), .req_divisor(req_divisor),
      .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz),
      .div_enable(div_enable), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Divider model: result valid only after LAT-1 prior enabled edges with unchanged operands.
   int          en_cnt = 0;
   logic        stab   = 1'b1;
   logic [31:0] prev_a = '0;
   logic [31:0] prev_b = '0;
   always @(posedge clk) begin
      if (!div_enable) begin
         en_cnt <= 0;
         stab   <= 1'b1;
      end else begin
         en_cnt <= en_cnt + 1;
         if (en_cnt != 0 && (div_dividend != prev_a || div_divisor != prev_b)) stab <= 1'b0;
      end
      prev_a <= div_dividend;
      prev_b <= div_divisor;
   end
   assign div_quotient  = (div_enable && stab && en_cnt >= LAT-1 && div_divisor != 0) ? div_dividend / div_divisor : 32'hDEAD_BEEF;
   assign div_remainder = (div_enable && stab && en_cnt >= LAT-1 && div_divisor != 0) ? div_dividend % div_divisor : 32'hBAAD_F00D;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } exp_t;
   exp_t sb[$];

   int passed = 0;
   int total  = 0;

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_dividend[i*32 +: 32] = a;
      req_divisor[i*32 +: 32]  = b;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      nxt();
      reset = 1'b1;
      nxt();
   endtask

   // Waits (bounded) for a grant; returns the grant vector and the cycle it was seen.
   task automatic issue(output logic [3:0] g, output int t);
      g = '0;
      t = -1;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (gnt !== 4'b0) begin
            g = gnt;
            t = cyc;
            return;
         end
         nxt();
      end
   endtask

   // Waits (bounded) for rsp_valid; counts div_enable cycles on the way.
   task automatic collect(input logic [3:0] keep, input int t, output logic seen, output int lat,
                          output int en, output exp_t o);
      seen = 1'b0;
      lat  = -1;
      en   = 0;
      o    = '{2'd0, 32'd0, 32'd0, 1'b0};
      for (int i = 0; i < 100; i++) begin
         nxt();
         if (i == 0) req = keep;
         #1;
         if (rsp_valid === 1'b1) begin
            seen = 1'b1;
            lat  = cyc - t;
            o    = '{rsp_id, rsp_quotient, rsp_remainder, rsp_dbz};
            return;
         end
         if (div_enable === 1'b1) en++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req   = '0;
      nxt();
      req = 4'hF;
      set_op(0, 32'd9, 32'd0);
      #1;
      total++; if (gnt !== 4'b0) $display("FAIL rst_gnt: got %b want 0000", gnt); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
      total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passed++;
      total++; if (div_enable !== 1'b0) $display("FAIL rst_div_enable: got %b want 0", div_enable); else passed++;
      total++; if (div_dividend !== 32'd0 || div_divisor !== 32'd0) $display("FAIL rst_div_ops: got %h/%h want 0/0", div_dividend, div_divisor); else passed++;
      total++; if (rsp_id !== 2'd0 || rsp_dbz !== 1'b0) $display("FAIL rst_rsp_id_dbz: got %0d/%b want 0/0", rsp_id, rsp_dbz); else passed++;
      total++; if (rsp_quotient !== 32'd0 || rsp_remainder !== 32'd0) $display("FAIL rst_rsp_qr: got %h/%h want 0/0", rsp_quotient, rsp_remainder); else passed++;
      req = '0;
      set_op(0, 32'd0, 32'd0);
      nxt();
      reset = 1'b1;
      nxt();
      #1;
      total++; if (busy !== 1'b0 || gnt !== 4'b0) $display("FAIL idle_quiet: got busy=%b gnt=%b want 0/0000", busy, gnt); else passed++;
   endtask

   task automatic test_normal();
      logic [3:0] g; int t; logic seen; int lat; int en; exp_t o; exp_t e;
      rsp_ready = 1'b1;
      set_op(0, 32'd183, 32'd14);
      req = 4'b0001;
      sb.push_back('{2'd0, 32'd13, 32'd1, 1'b0});
      issue(g, t);
      total++; if (g !== 4'b0001) $display("FAIL norm_gnt: got %b want 0001", g); else passed++;
      collect(4'b0000, t, seen, lat, en, o);
      total++; if (seen !== 1'b1) $display("FAIL norm_seen: got %b want 1", seen); else passed++;
      total++; if (lat != LAT+1) $display("FAIL norm_latency: got %0d want %0d", lat, LAT+1); else passed++;
      total++; if (en != LAT) $display("FAIL norm_enable_cycles: got %0d want %0d", en, LAT); else passed++;
      e = '{2'd3, 32'd0, 32'd0, 1'b1};
      if (sb.size() != 0) e = sb.pop_front();
      total++; if (o.id !== e.id || o.dbz !== e.dbz) $display("FAIL norm_id_dbz: got %0d/%b want %0d/%b", o.id, o.dbz, e.id, e.dbz); else passed++;
      total++; if (o.q !== e.q || o.r !== e.r) $display("FAIL norm_qr: got %0d/%0d want %0d/%0d", o.q, o.r, e.q, e.r); else passed++;
      nxt();
      #1;
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL norm_after_hs: got valid=%b busy=%b want 0/0", rsp_valid, busy); else passed++;
   endtask

   task automatic test_dbz();
      logic [3:0] g; int t; logic seen; int lat; int en; exp_t o; exp_t e;
      rsp_ready = 1'b1;
      set_op(1, 32'd13, 32'd0);
      req = 4'b0010;
      sb.push_back('{2'd1, 32'hFFFF_FFFF, 32'd13, 1'b1});
      issue(g, t);
      total++; if (g !== 4'b0010) $display("FAIL dbz_gnt: got %b want 0010", g); else passed++;
      collect(4'b0000, t, seen, lat, en, o);
      total++; if (seen !== 1'b1 || lat != 1) $display("FAIL dbz_latency: got seen=%b lat=%0d want 1/1", seen, lat); else passed++;
      total++; if (en != 0 || div_enable !== 1'b0) $display("FAIL dbz_enable: got %0d cycles want 0", en); else passed++;
      e = '{2'd3, 32'd0, 32'd0, 1'b0};
      if (sb.size() != 0) e = sb.pop_front();
      total++; if (o.id !== e.id || o.dbz !== e.dbz) $display("FAIL dbz_id_flag: got %0d/%b want %0d/%b", o.id, o.dbz, e.id, e.dbz); else passed++;
      total++; if (o.q !== e.q || o.r !== e.r) $display("FAIL dbz_qr: got %h/%0d want %h/%0d", o.q, o.r, e.q, e.r); else passed++;
      nxt();
   endtask

   task automatic test_round_robin();
      logic [3:0] g; int t; logic seen; int lat; int en; exp_t o; exp_t e; logic [1:0] id;
      do_reset();
      rsp_ready = 1'b1;
      set_op(0, 32'd100, 32'd7);
      set_op(2, 32'd200, 32'd9);
      req = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         id = (k % 2 == 0) ? 2'd0 : 2'd2;
         sb.push_back((id == 2'd0) ? '{2'd0, 32'd14, 32'd2, 1'b0} : '{2'd2, 32'd22, 32'd2, 1'b0});
         issue(g, t);
         total++; if (g !== (4'b0001 << id)) $display("FAIL rr_gnt%0d: got %b want %b", k, g, 4'b0001 << id); else passed++;
         collect(4'b0101, t, seen, lat, en, o);
         e = '{2'd3, 32'd0, 32'd0, 1'b1};
         if (sb.size() != 0) e = sb.pop_front();
         total++; if (seen !== 1'b1 || o.id !== e.id) $display("FAIL rr_id%0d: got %0d want %0d", k, o.id, e.id); else passed++;
         total++; if (o.q !== e.q || o.r !== e.r || o.dbz !== e.dbz) $display("FAIL rr_qr%0d: got %0d/%0d want %0d/%0d", k, o.q, o.r, e.q, e.r); else passed++;
      end
      req = '0;
      nxt();
   endtask

   task automatic test_backpressure();
      logic [3:0] g; int t; logic seen; int lat; int en; exp_t o; exp_t e;
      rsp_ready = 1'b0;
      set_op(1, 32'd77, 32'd0);
      set_op(0, 32'd50, 32'd5);
      req = 4'b0010;
      sb.push_back('{2'd1, 32'hFFFF_FFFF, 32'd77, 1'b1});
      issue(g, t);
      total++; if (g !== 4'b0010) $display("FAIL bp_gnt: got %b want 0010", g); else passed++;
      collect(4'b0001, t, seen, lat, en, o);
      e = '{2'd3, 32'd0, 32'd0, 1'b0};
      if (sb.size() != 0) e = sb.pop_front();
      total++; if (seen !== 1'b1 || o.id !== e.id || o.r !== e.r || o.dbz !== e.dbz) $display("FAIL bp_rsp: got id=%0d r=%0d dbz=%b want %0d/%0d/%b", o.id, o.r, o.dbz, e.id, e.r, e.dbz); else passed++;
      for (int i = 0; i < 5; i++) begin
         nxt();
         #1;
         total++; if (rsp_valid !== 1'b1 || busy !== 1'b1) $display("FAIL bp_hold_valid%0d: got valid=%b busy=%b want 1/1", i, rsp_valid, busy); else passed++;
         total++; if (rsp_id !== e.id || rsp_quotient !== e.q || rsp_remainder !== e.r || rsp_dbz !== e.dbz) $display("FAIL bp_hold_data%0d: got %0d/%h/%0d/%b want %0d/%h/%0d/%b", i, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, e.id, e.q, e.r, e.dbz); else passed++;
         total++; if (gnt !== 4'b0) $display("FAIL bp_no_gnt%0d: got %b want 0000", i, gnt); else passed++;
      end
      rsp_ready = 1'b1;
      sb.push_back('{2'd0, 32'd10, 32'd0, 1'b0});
      nxt();
      #1;
      total++; if (gnt !== 4'b0001 || rsp_valid !== 1'b0) $display("FAIL bp_next_gnt: got gnt=%b valid=%b want 0001/0", gnt, rsp_valid); else passed++;
      t = cyc;
      collect(4'b0000, t, seen, lat, en, o);
      e = '{2'd3, 32'd0, 32'd0, 1'b1};
      if (sb.size() != 0) e = sb.pop_front();
      total++; if (seen !== 1'b1 || lat != LAT+1 || o.q !== e.q || o.id !== e.id) $display("FAIL bp_second: got lat=%0d q=%0d id=%0d want %0d/%0d/%0d", lat, o.q, o.id, LAT+1, e.q, e.id); else passed++;
      nxt();
   endtask

   task automatic test_reset_mid_run();
      logic [3:0] g; int t; logic seen; int lat; int en; exp_t o; exp_t e;
      rsp_ready = 1'b1;
      set_op(0, 32'd1000, 32'd3);
      set_op(2, 32'd40, 32'd6);
      req = 4'b0001;
      issue(g, t);
      total++; if (g !== 4'b0001) $display("FAIL rmr_gnt: got %b want 0001", g); else passed++;
      nxt();
      req = 4'b0101;
      repeat (9) nxt();
      reset = 1'b0;
      #1;
      total++; if (rsp_valid !== 1'b0 || div_enable !== 1'b0) $display("FAIL rmr_abort: got valid=%b en=%b want 0/0", rsp_valid, div_enable); else passed++;
      total++; if (gnt !== 4'b0 || busy !== 1'b0) $display("FAIL rmr_gnt_busy: got gnt=%b busy=%b want 0000/0", gnt, busy); else passed++;
      total++; if (div_dividend !== 32'd0 || div_divisor !== 32'd0) $display("FAIL rmr_ops: got %h/%h want 0/0", div_dividend, div_divisor); else passed++;
      nxt();
      reset = 1'b1;
      sb.push_back('{2'd0, 32'd333, 32'd1, 1'b0});
      #1;
      total++; if (gnt !== 4'b0001) $display("FAIL rmr_ptr_reset: got %b want 0001", gnt); else passed++;
      t = cyc;
      collect(4'b0000, t, seen, lat, en, o);
      e = '{2'd3, 32'd0, 32'd0, 1'b1};
      if (sb.size() != 0) e = sb.pop_front();
      total++; if (seen !== 1'b1 || o.id !== e.id || o.q !== e.q || o.r !== e.r) $display("FAIL rmr_result: got %0d/%0d/%0d want %0d/%0d/%0d", o.id, o.q, o.r, e.id, e.q, e.r); else passed++;
      nxt();
   endtask

   task automatic test_fastpath();
      logic [3:0] g; int t; logic seen; int lat; int en; exp_t o; exp_t e;
      rsp_ready = 1'b1;
      set_op(3, 32'd153, 32'd1);
      set_op(2, 32'd5, 32'd9);
      sb.push_back('{2'd3, 32'd153, 32'd0, 1'b0});
      sb.push_back('{2'd2, 32'd0, 32'd5, 1'b0});
      for (int k = 0; k < 2; k++) begin
         req = (k == 0) ? 4'b1000 : 4'b0100;
         issue(g, t);
         total++; if (g !== req) $display("FAIL fp_gnt%0d: got %b want %b", k, g, req); else passed++;
         collect(4'b0000, t, seen, lat, en, o);
         total++; if (seen !== 1'b1 || lat != FP_LAT || en != FP_EN) $display("FAIL fp_timing%0d: got lat=%0d en=%0d want %0d/%0d", k, lat, en, FP_LAT, FP_EN); else passed++;
         e = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
         if (sb.size() != 0) e = sb.pop_front();
         total++; if (o.id !== e.id || o.q !== e.q || o.r !== e.r || o.dbz !== e.dbz) $display("FAIL fp_result%0d: got %0d/%0d/%0d/%b want %0d/%0d/%0d/%b", k, o.id, o.q, o.r, o.dbz, e.id, e.q, e.r, e.dbz); else passed++;
         nxt();
      end
   endtask

   initial begin
      reset        = 1'b0;
      req          = '0;
      rsp_ready    = 1'b0;
      req_dividend = '0;
      req_divisor  = '0;
      test_reset();
      test_normal();
      test_dbz();
      test_round_robin();
      test_backpressure();
      test_reset_mid_run();
      test_fastpath();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
